// File: rtl/regstate_checker.sv
// Register-state scoreboard: buffers expected CPU register vectors in a FIFO
// and compares the head entry against the live register file on each retire.
// It applies per-channel masks, counts compared and failed vectors, and
// finishes the run when a STOP opcode retires.
module regstate_checker #(
    parameter int unsigned     NUM_REGS = 8,
    parameter int unsigned     REG_W    = 8,
    parameter int unsigned     OP_W     = 8,
    parameter int unsigned     DEPTH    = 16,
    parameter logic [OP_W-1:0] STOP_OP  = 'h10,
    parameter int unsigned     CNT_W    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      exp_valid,
    output logic                      exp_ready,
    input  logic [OP_W-1:0]           exp_op,
    input  logic [NUM_REGS*REG_W-1:0] exp_regs,
    input  logic [NUM_REGS-1:0]       exp_mask,
    input  logic                      retire,
    input  logic [OP_W-1:0]           retire_op,
    input  logic [NUM_REGS*REG_W-1:0] dut_regs,
    output logic                      mismatch,
    output logic [NUM_REGS-1:0]       mismatch_regs,
    output logic                      op_mismatch,
    output logic                      underflow,
    output logic [CNT_W-1:0]          vec_count,
    output logic [CNT_W-1:0]          err_count,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      done
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    logic [OP_W-1:0]           mem_op   [DEPTH];
    logic [NUM_REGS*REG_W-1:0] mem_regs [DEPTH];
    logic [NUM_REGS-1:0]       mem_mask [DEPTH];

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  mismatch_q, mismatch_d;
    logic [NUM_REGS-1:0]   mismatch_regs_q, mismatch_regs_d;
    logic                  op_mismatch_q, op_mismatch_d;
    logic                  underflow_q, underflow_d;
    logic [CNT_W-1:0]      vec_count_q, vec_count_d;
    logic [CNT_W-1:0]      err_count_q, err_count_d;
    logic                  done_q, done_d;

    logic                  push, pop, empty;
    logic                  cmp_evt, stop_evt, op_fail;
    logic [NUM_REGS-1:0]   ch_fail;

    // Readiness comes from registered state only, so a pop cannot open a slot in the same cycle
    assign exp_ready = (level_q != FULL_LVL) && (state_q != ST_DONE);
    assign push      = exp_valid && exp_ready;
    assign empty     = (level_q == '0);

    // Per-channel and opcode compare of the FIFO head against the live register file
    always_comb begin
        ch_fail = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            ch_fail[i] = mem_mask[rd_ptr_q][i] &&
                         (dut_regs[i*REG_W +: REG_W] !== mem_regs[rd_ptr_q][i*REG_W +: REG_W]);
        end
        op_fail = (retire_op !== mem_op[rd_ptr_q]);
    end

    // Next-state logic: FSM, FIFO pointers, compare results and saturating counters
    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        mismatch_d      = 1'b0;
        mismatch_regs_d = mismatch_regs_q;
        op_mismatch_d   = op_mismatch_q;
        underflow_d     = underflow_q;
        vec_count_d     = vec_count_q;
        err_count_d     = err_count_q;
        done_d          = done_q;
        pop             = 1'b0;

        stop_evt = retire && (state_q == ST_RUN) && (retire_op == STOP_OP);
        cmp_evt  = retire && (state_q != ST_DONE) && !stop_evt;

        if (stop_evt) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
        end

        if (cmp_evt) begin
            if ((state_q == ST_IDLE) && (retire_op != STOP_OP)) begin
                state_d = ST_RUN;
            end
            if (empty) begin
                // The vector pushed in this cycle is stored, not bypassed
                underflow_d     = 1'b1;
                mismatch_d      = 1'b1;
                mismatch_regs_d = '0;
                op_mismatch_d   = 1'b0;
                if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
            end else begin
                pop             = 1'b1;
                mismatch_regs_d = ch_fail;
                op_mismatch_d   = op_fail;
                mismatch_d      = (|ch_fail) || op_fail;
                if (vec_count_q != '1) vec_count_d = vec_count_q + CNT_W'(1);
                if (((|ch_fail) || op_fail) && (err_count_q != '1)) begin
                    err_count_d = err_count_q + CNT_W'(1);
                end
            end
        end

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
            mismatch_q      <= 1'b0;
            mismatch_regs_q <= '0;
            op_mismatch_q   <= 1'b0;
            underflow_q     <= 1'b0;
            vec_count_q     <= '0;
            err_count_q     <= '0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            level_q         <= level_d;
            mismatch_q      <= mismatch_d;
            mismatch_regs_q <= mismatch_regs_d;
            op_mismatch_q   <= op_mismatch_d;
            underflow_q     <= underflow_d;
            vec_count_q     <= vec_count_d;
            err_count_q     <= err_count_d;
            done_q          <= done_d;
        end
    end

    // Expected-vector storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[wr_ptr_q]   <= exp_op;
            mem_regs[wr_ptr_q] <= exp_regs;
            mem_mask[wr_ptr_q] <= exp_mask;
        end
    end

    assign mismatch      = mismatch_q;
    assign mismatch_regs = mismatch_regs_q;
    assign op_mismatch   = op_mismatch_q;
    assign underflow     = underflow_q;
    assign vec_count     = vec_count_q;
    assign err_count     = err_count_q;
    assign level         = level_q;
    assign done          = done_q;

endmodule

// File: tb/tb_regstate_checker.sv
// Testbench for regstate_checker: directed steps from the test plan followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_regstate_checker;

    localparam int NR    = 8;
    localparam int RW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 6;
    localparam logic [7:0] STOP = 8'h10;
    localparam int SAT   = (1 << CW) - 1;

    typedef struct {
        logic [7:0]  op;
        logic [63:0] regs;
        logic [7:0]  mask;
    } vec_t;

    logic          clk, rst;
    logic          exp_valid, exp_ready;
    logic [7:0]    exp_op, exp_mask, retire_op;
    logic [63:0]   exp_regs, dut_regs;
    logic          retire;
    logic          mismatch, op_mismatch, underflow, done;
    logic [7:0]    mismatch_regs;
    logic [CW-1:0] vec_count, err_count;
    logic [4:0]    level;

    regstate_checker #(
        .NUM_REGS(NR), .REG_W(RW), .OP_W(8), .DEPTH(DEPTH),
        .STOP_OP(STOP), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .exp_valid(exp_valid), .exp_ready(exp_ready),
        .exp_op(exp_op), .exp_regs(exp_regs), .exp_mask(exp_mask),
        .retire(retire), .retire_op(retire_op), .dut_regs(dut_regs),
        .mismatch(mismatch), .mismatch_regs(mismatch_regs),
        .op_mismatch(op_mismatch), .underflow(underflow),
        .vec_count(vec_count), .err_count(err_count),
        .level(level), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    vec_t     q[$];
    int       m_vec, m_err;
    bit       m_under, m_mm, m_opmm, m_done, m_running;
    bit [7:0] m_mregs;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_vec = 0; m_err = 0;
        m_under = 0; m_mm = 0; m_opmm = 0; m_done = 0; m_running = 0;
        m_mregs = '0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".mismatch"},  64'(mismatch),      64'(m_mm));
        check({tag, ".mregs"},     64'(mismatch_regs), 64'(m_mregs));
        check({tag, ".opmm"},      64'(op_mismatch),   64'(m_opmm));
        check({tag, ".underflow"}, 64'(underflow),     64'(m_under));
        check({tag, ".vec"},       64'(vec_count),     64'(m_vec));
        check({tag, ".err"},       64'(err_count),     64'(m_err));
        check({tag, ".level"},     64'(level),         64'(q.size()));
        check({tag, ".done"},      64'(done),          64'(m_done));
    endtask

    // One clock cycle with the currently driven inputs, advancing the model
    task automatic tick(input string tag);
        bit       ready, push, opm;
        bit [7:0] fails;
        vec_t     h;
        vec_t     nv;
        ready = (q.size() < DEPTH) && !m_done;
        check({tag, ".exp_ready"}, 64'(exp_ready), 64'(ready));
        push = exp_valid && ready;
        nv.op = exp_op; nv.regs = exp_regs; nv.mask = exp_mask;
        m_mm = 0;
        if (retire && !m_done) begin
            if (m_running && retire_op == STOP) begin
                m_done = 1;
            end else begin
                if (retire_op != STOP) m_running = 1;
                if (q.size() == 0) begin
                    m_under = 1; m_mm = 1; m_mregs = '0; m_opmm = 0;
                    if (m_err < SAT) m_err++;
                end else begin
                    h = q.pop_front();
                    fails = '0;
                    for (int i = 0; i < NR; i++)
                        if (h.mask[i] && (dut_regs[i*RW +: RW] != h.regs[i*RW +: RW])) fails[i] = 1;
                    opm = (retire_op != h.op);
                    m_mregs = fails; m_opmm = opm;
                    m_mm = (fails != 0) || opm;
                    if (m_vec < SAT) m_vec++;
                    if (m_mm && m_err < SAT) m_err++;
                end
            end
        end
        if (push) q.push_back(nv);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        exp_valid = 0; retire = 0;
    endtask

    task automatic push_vec(input logic [7:0] op, input logic [63:0] regs, input logic [7:0] mask);
        idle_inputs();
        exp_valid = 1; exp_op = op; exp_regs = regs; exp_mask = mask;
        tick("push");
        idle_inputs();
    endtask

    task automatic retire_with(input logic [7:0] op, input logic [63:0] regs);
        idle_inputs();
        retire = 1; retire_op = op; dut_regs = regs;
        tick("retire");
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        rst = 0;
        check_all("rst_rel");
    endtask

    // Register order A,B,C,D,E,H,L,F from MSB to LSB; F is channel 0
    function automatic logic [63:0] mk(input logic [7:0] a, b, f);
        return {a, b, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, f};
    endfunction

    initial begin
        rst = 1; exp_valid = 0; retire = 0;
        exp_op = '0; exp_regs = '0; exp_mask = '0; retire_op = '0; dut_regs = '0;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk); #1;
        rst = 0;

        // Three matching vectors
        for (int i = 0; i < 3; i++) push_vec(8'h3E, mk(8'h05, 8'h00, 8'h00), 8'hFF);
        for (int i = 0; i < 3; i++) retire_with(8'h3E, mk(8'h05, 8'h00, 8'h00));
        check("tp_vec3", 64'(vec_count), 64'd3);
        check("tp_err0", 64'(err_count), 64'd0);
        check("tp_lvl0", 64'(level), 64'd0);

        // B mismatch
        push_vec(8'h3E, mk(8'h05, 8'h13, 8'h00), 8'hFF);
        retire_with(8'h3E, mk(8'h05, 8'h12, 8'h00));
        check("tp_b_mm",    64'(mismatch), 64'd1);
        check("tp_b_mregs", 64'(mismatch_regs), 64'h40);
        check("tp_b_err",   64'(err_count), 64'd1);
        tick("b_pulse_end");
        check("tp_b_pulse", 64'(mismatch), 64'd0);

        // B masked off, then F and opcode mismatch
        push_vec(8'h3E, mk(8'h05, 8'h13, 8'h00), 8'hBF);
        retire_with(8'h3E, mk(8'h05, 8'h12, 8'h00));
        check("tp_mask_mm", 64'(mismatch), 64'd0);
        push_vec(8'h81, mk(8'h00, 8'h00, 8'h01), 8'hFF);
        retire_with(8'h80, mk(8'h00, 8'h00, 8'h00));
        check("tp_f_mregs", 64'(mismatch_regs), 64'h01);
        check("tp_f_opmm",  64'(op_mismatch), 64'd1);

        // Fill to full, refused push during a pop, then accepted next cycle
        for (int i = 0; i < DEPTH; i++) push_vec(8'h3E, mk(8'h00, 8'(i), 8'h00), 8'hFF);
        check("tp_full_rdy", 64'(exp_ready), 64'd0);
        exp_valid = 1; exp_op = 8'h3E; exp_regs = mk(8'hAA, 8'h00, 8'h00); exp_mask = 8'hFF;
        retire = 1; retire_op = 8'h3E; dut_regs = mk(8'h00, 8'h00, 8'h00);
        tick("full_pop");
        check("tp_lvl15", 64'(level), 64'd15);
        retire = 0;
        tick("refill");
        check("tp_lvl16", 64'(level), 64'd16);
        idle_inputs();
        while (q.size() > 0) retire_with(q[0].op, q[0].regs);

        // Underflow, then STOP after a plain retire
        retire_with(8'h3E, '0);
        check("tp_under", 64'(underflow), 64'd1);
        retire_with(8'h00, '0);
        retire_with(STOP, '0);
        check("tp_done", 64'(done), 64'd1);
        push_vec(8'h3E, '0, 8'hFF);
        retire_with(8'h3E, '0);
        retire_with(8'h00, '0);

        // Reset asserted between a retire and its result edge
        do_reset();
        push_vec(8'h3E, mk(8'h01, 8'h00, 8'h00), 8'hFF);
        push_vec(8'h3E, mk(8'h01, 8'h00, 8'h00), 8'hFF);
        retire_with(8'h3E, mk(8'h01, 8'h00, 8'h00));
        retire = 1; retire_op = 8'h3E; dut_regs = mk(8'h02, 8'h00, 8'h00);
        #3;
        rst = 1;
        #1;
        model_reset();
        check_all("mid_rst");
        retire = 0;
        @(posedge clk); #1;
        rst = 0;
        tick("post_rst");
        check("tp_no_pulse", 64'(mismatch), 64'd0);

        // STOP retiring in IDLE compares and stays out of DONE
        push_vec(STOP, '0, 8'hFF);
        retire_with(STOP, '0);
        check("tp_idle_stop_done", 64'(done), 64'd0);
        check("tp_idle_stop_vec",  64'(vec_count), 64'd1);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            if (n % 400 == 399) do_reset();
            exp_valid = ($urandom_range(0, 2) != 0);
            exp_op    = ($urandom_range(0, 1) != 0) ? 8'h3E : 8'(($urandom_range(0, 3)) + 8'h80);
            exp_regs  = {$urandom, $urandom};
            exp_mask  = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
            retire    = ($urandom_range(0, 2) == 0);
            if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
                retire_op = q[0].op;
                dut_regs  = q[0].regs;
                if ($urandom_range(0, 3) == 0) dut_regs[$urandom_range(0, 63)] ^= 1'b1;
                if ($urandom_range(0, 7) == 0) retire_op = 8'($urandom);
            end else begin
                retire_op = 8'($urandom);
                dut_regs  = {$urandom, $urandom};
            end
            if ($urandom_range(0, 99) == 0) retire_op = STOP;
            tick("rand");
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
